dtcm_arbt: RTL and testbench

Two-requester arbiter sharing the single DTCM controller port between the core LSU and an external requester (system-bus/debug/DMA slave port). It sits between the core's `lsu2dtcm_*` port, the external port and the DTCM controller. Round-robin grant with grant lock while a command is stalled; a small source-ID FIFO routes in-order DTCM responses back to the requester that issued each command.

---
 rtl/dtcm_arbt_pkg.sv | 7 +
 rtl/dtcm_src_fifo.sv | 43 ++++
 rtl/dtcm_arbt.sv | 82 ++++++++
 tb/tb_dtcm_arbt.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/dtcm_arbt_pkg.sv
// dtcm_arbt_pkg: shared widths, defaults and source IDs for the DTCM port arbiter
package dtcm_arbt_pkg;
    localparam int XLEN = 32;
    localparam int DTCM_ADDR_WIDTH = 16;
    localparam int DTCM_ARBT_OUTS_DEPTH = 2;
    typedef enum logic {DTCM_SRC_LSU = 1'b0, DTCM_SRC_EXT = 1'b1} dtcm_src_e;
endpackage

// File: rtl/dtcm_src_fifo.sv
// dtcm_src_fifo: 1-bit-wide sync FIFO of command source IDs, with full/empty
module dtcm_src_fifo #(
    parameter int DEPTH = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic push,
    input  logic pop,
    input  logic din,
    output logic dout,
    output logic full,
    output logic empty
);
    localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    logic [DEPTH-1:0] mem;
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] cnt;
    logic do_push, do_pop;
    function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
        return p == PW'(DEPTH - 1) ? '0 : p + 1'b1;
    endfunction
    assign full = cnt == CW'(DEPTH);
    assign empty = cnt == '0;
    assign do_push = push & ~full;
    assign do_pop = pop & ~empty;
    assign dout = mem[rd_ptr];
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr <= inc(wr_ptr);
            end
            if (do_pop) rd_ptr <= inc(rd_ptr);
            cnt <= cnt + CW'(do_push) - CW'(do_pop);
        end
    end
endmodule

// File: rtl/dtcm_arbt.sv
// dtcm_arbt: round-robin LSU/external arbiter for the DTCM port, in-order response routing
module dtcm_arbt
    import dtcm_arbt_pkg::*;
#(
    parameter int OUTS_DEPTH = DTCM_ARBT_OUTS_DEPTH
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       lsu_cmd_valid,
    output logic                       lsu_cmd_ready,
    input  logic                       lsu_cmd_read,
    input  logic [DTCM_ADDR_WIDTH-1:0] lsu_cmd_addr,
    input  logic [XLEN-1:0]            lsu_cmd_wdata,
    input  logic [XLEN/8-1:0]          lsu_cmd_wmask,
    output logic                       lsu_rsp_valid,
    input  logic                       lsu_rsp_ready,
    output logic [XLEN-1:0]            lsu_rsp_rdata,
    input  logic                       ext_cmd_valid,
    output logic                       ext_cmd_ready,
    input  logic                       ext_cmd_read,
    input  logic [DTCM_ADDR_WIDTH-1:0] ext_cmd_addr,
    input  logic [XLEN-1:0]            ext_cmd_wdata,
    input  logic [XLEN/8-1:0]          ext_cmd_wmask,
    output logic                       ext_rsp_valid,
    input  logic                       ext_rsp_ready,
    output logic [XLEN-1:0]            ext_rsp_rdata,
    output logic                       dtcm_cmd_valid,
    input  logic                       dtcm_cmd_ready,
    output logic                       dtcm_cmd_read,
    output logic [DTCM_ADDR_WIDTH-1:0] dtcm_cmd_addr,
    output logic [XLEN-1:0]            dtcm_cmd_wdata,
    output logic [XLEN/8-1:0]          dtcm_cmd_wmask,
    input  logic                       dtcm_rsp_valid,
    output logic                       dtcm_rsp_ready,
    input  logic [XLEN-1:0]            dtcm_rsp_rdata
);
    dtcm_src_e last_grant, lock_src, gnt;
    logic lock_vld, gnt_ext, fifo_full, fifo_empty, head, sel_rsp_ready;
    always_comb begin
        gnt = lock_vld ? lock_src
            : (lsu_cmd_valid & ext_cmd_valid) ? dtcm_src_e'(~last_grant)
            : ext_cmd_valid ? DTCM_SRC_EXT : DTCM_SRC_LSU;
    end
    assign gnt_ext = gnt == DTCM_SRC_EXT;
    // Valid never looks at dtcm_cmd_ready, so no combinational loop through the controller.
    assign dtcm_cmd_valid = (gnt_ext ? ext_cmd_valid : lsu_cmd_valid) & ~fifo_full;
    assign dtcm_cmd_read  = gnt_ext ? ext_cmd_read  : lsu_cmd_read;
    assign dtcm_cmd_addr  = gnt_ext ? ext_cmd_addr  : lsu_cmd_addr;
    assign dtcm_cmd_wdata = gnt_ext ? ext_cmd_wdata : lsu_cmd_wdata;
    assign dtcm_cmd_wmask = gnt_ext ? ext_cmd_wmask : lsu_cmd_wmask;
    assign lsu_cmd_ready  = ~gnt_ext & dtcm_cmd_ready & ~fifo_full;
    assign ext_cmd_ready  = gnt_ext & dtcm_cmd_ready & ~fifo_full;
    assign sel_rsp_ready  = head ? ext_rsp_ready : lsu_rsp_ready;
    assign dtcm_rsp_ready = ~fifo_empty & sel_rsp_ready;
    assign lsu_rsp_valid  = dtcm_rsp_valid & ~fifo_empty & ~head;
    assign ext_rsp_valid  = dtcm_rsp_valid & ~fifo_empty & head;
    assign lsu_rsp_rdata  = dtcm_rsp_rdata;
    assign ext_rsp_rdata  = dtcm_rsp_rdata;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= DTCM_SRC_EXT;
            lock_vld <= 1'b0;
            lock_src <= DTCM_SRC_LSU;
        end else if (dtcm_cmd_valid & dtcm_cmd_ready) begin
            last_grant <= gnt;
            lock_vld <= 1'b0;
        end else if (dtcm_cmd_valid) begin
            lock_vld <= 1'b1;
            lock_src <= gnt;
        end
    end
    dtcm_src_fifo #(.DEPTH(OUTS_DEPTH)) u_src_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (dtcm_cmd_valid & dtcm_cmd_ready),
        .pop   (dtcm_rsp_valid & dtcm_rsp_ready),
        .din   (gnt),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );
endmodule

// File: tb/tb_dtcm_arbt.sv
// tb_dtcm_arbt: table-driven cycle vectors plus a source-ID scoreboard for response routing
module tb_dtcm_arbt;
    import dtcm_arbt_pkg::*;
    localparam logic [15:0] LA = 16'h0010, EA = 16'h0300;
    localparam logic [31:0] LW = 32'h1111_1111, EW = 32'hCAFE_F00D;
    localparam logic [3:0]  LM = 4'hF, EM = 4'h5;
    typedef struct {
        logic lv, ev, cr, rv, lrr, err;
        logic [31:0] rd;
        logic dv, lr, er, src, drr;
    } vec_t;
    logic clk, rst_n;
    logic lsu_cmd_valid, lsu_cmd_ready, lsu_cmd_read, lsu_rsp_valid, lsu_rsp_ready;
    logic [15:0] lsu_cmd_addr, ext_cmd_addr, dtcm_cmd_addr;
    logic [31:0] lsu_cmd_wdata, ext_cmd_wdata, dtcm_cmd_wdata, lsu_rsp_rdata, ext_rsp_rdata, dtcm_rsp_rdata;
    logic [3:0] lsu_cmd_wmask, ext_cmd_wmask, dtcm_cmd_wmask;
    logic ext_cmd_valid, ext_cmd_ready, ext_cmd_read, ext_rsp_valid, ext_rsp_ready;
    logic dtcm_cmd_valid, dtcm_cmd_ready, dtcm_cmd_read, dtcm_rsp_valid, dtcm_rsp_ready;
    int n_chk = 0, n_fail = 0;
    logic q[$];
    vec_t tbl[15];

    dtcm_arbt #(.OUTS_DEPTH(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .lsu_cmd_valid(lsu_cmd_valid), .lsu_cmd_ready(lsu_cmd_ready), .lsu_cmd_read(lsu_cmd_read),
        .lsu_cmd_addr(lsu_cmd_addr), .lsu_cmd_wdata(lsu_cmd_wdata), .lsu_cmd_wmask(lsu_cmd_wmask),
        .lsu_rsp_valid(lsu_rsp_valid), .lsu_rsp_ready(lsu_rsp_ready), .lsu_rsp_rdata(lsu_rsp_rdata),
        .ext_cmd_valid(ext_cmd_valid), .ext_cmd_ready(ext_cmd_ready), .ext_cmd_read(ext_cmd_read),
        .ext_cmd_addr(ext_cmd_addr), .ext_cmd_wdata(ext_cmd_wdata), .ext_cmd_wmask(ext_cmd_wmask),
        .ext_rsp_valid(ext_rsp_valid), .ext_rsp_ready(ext_rsp_ready), .ext_rsp_rdata(ext_rsp_rdata),
        .dtcm_cmd_valid(dtcm_cmd_valid), .dtcm_cmd_ready(dtcm_cmd_ready), .dtcm_cmd_read(dtcm_cmd_read),
        .dtcm_cmd_addr(dtcm_cmd_addr), .dtcm_cmd_wdata(dtcm_cmd_wdata), .dtcm_cmd_wmask(dtcm_cmd_wmask),
        .dtcm_rsp_valid(dtcm_rsp_valid), .dtcm_rsp_ready(dtcm_rsp_ready), .dtcm_rsp_rdata(dtcm_rsp_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // One cycle: drive at negedge, check 1 time unit later, well before the next posedge.
    task automatic step(input vec_t v);
        @(negedge clk);
        lsu_cmd_valid = v.lv;
        ext_cmd_valid = v.ev;
        dtcm_cmd_ready = v.cr;
        dtcm_rsp_valid = v.rv;
        lsu_rsp_ready = v.lrr;
        ext_rsp_ready = v.err;
        dtcm_rsp_rdata = v.rd;
        #1;
        chk("dtcm_cmd_valid", dtcm_cmd_valid, v.dv);
        chk("lsu_cmd_ready", lsu_cmd_ready, v.lr);
        chk("ext_cmd_ready", ext_cmd_ready, v.er);
        chk("dtcm_rsp_ready", dtcm_rsp_ready, v.drr);
        if (v.dv) begin
            chk("cmd_addr", dtcm_cmd_addr, v.src ? EA : LA);
            chk("cmd_wdata", dtcm_cmd_wdata, v.src ? EW : LW);
            chk("cmd_wmask", dtcm_cmd_wmask, v.src ? EM : LM);
            chk("cmd_read", dtcm_cmd_read, !v.src);
        end
        if (v.rv && q.size() > 0) begin
            chk("lsu_rsp_valid", lsu_rsp_valid, !q[0]);
            chk("ext_rsp_valid", ext_rsp_valid, q[0]);
            chk("rsp_rdata", q[0] ? ext_rsp_rdata : lsu_rsp_rdata, v.rd);
            if (v.drr) void'(q.pop_front());
        end else begin
            chk("lsu_rsp_valid_idle", lsu_rsp_valid, 1'b0);
            chk("ext_rsp_valid_idle", ext_rsp_valid, 1'b0);
        end
        if (v.dv && v.cr) q.push_back(v.src);
    endtask

    task automatic quiet_checks(input string tag);
        chk({tag, "_dtcm_cmd_valid"}, dtcm_cmd_valid, 1'b0);
        chk({tag, "_lsu_cmd_ready"}, lsu_cmd_ready, 1'b0);
        chk({tag, "_ext_cmd_ready"}, ext_cmd_ready, 1'b0);
        chk({tag, "_dtcm_rsp_ready"}, dtcm_rsp_ready, 1'b0);
        chk({tag, "_lsu_rsp_valid"}, lsu_rsp_valid, 1'b0);
        chk({tag, "_ext_rsp_valid"}, ext_rsp_valid, 1'b0);
        chk({tag, "_cmd_addr_lsu_mux"}, dtcm_cmd_addr, LA);
    endtask

    initial begin
        //         lv ev cr rv lrr err rd            dv lr er src drr
        tbl[0]  = '{1, 1, 1, 0, 0, 0, 32'h0,         1, 1, 0, 0, 0};
        tbl[1]  = '{1, 1, 1, 1, 1, 1, 32'hA000_0001, 1, 0, 1, 1, 1};
        tbl[2]  = '{1, 1, 1, 1, 1, 1, 32'hA000_0002, 1, 1, 0, 0, 1};
        tbl[3]  = '{1, 1, 1, 1, 1, 1, 32'hA000_0003, 1, 0, 1, 1, 1};
        tbl[4]  = '{0, 0, 1, 1, 1, 1, 32'hA000_0004, 0, 1, 0, 0, 1};
        tbl[5]  = '{1, 0, 1, 0, 0, 0, 32'h0,         1, 1, 0, 0, 0};
        tbl[6]  = '{1, 0, 1, 0, 0, 0, 32'h0,         1, 1, 0, 0, 0};
        tbl[7]  = '{1, 0, 1, 0, 1, 1, 32'h0,         0, 0, 0, 0, 1};
        tbl[8]  = '{1, 0, 1, 1, 1, 1, 32'hB000_0001, 0, 0, 0, 0, 1};
        tbl[9]  = '{1, 0, 1, 0, 0, 0, 32'h0,         1, 1, 0, 0, 0};
        tbl[10] = '{0, 0, 1, 1, 0, 1, 32'hB000_0002, 0, 0, 0, 0, 0};
        tbl[11] = '{0, 0, 1, 1, 0, 1, 32'hB000_0002, 0, 0, 0, 0, 0};
        tbl[12] = '{0, 0, 1, 1, 1, 1, 32'hB000_0002, 0, 0, 0, 0, 1};
        tbl[13] = '{0, 0, 1, 1, 1, 1, 32'hB000_0003, 0, 1, 0, 0, 1};
        tbl[14] = '{0, 1, 1, 0, 0, 0, 32'h0,         1, 0, 1, 1, 0};
        lsu_cmd_read = 1'b1; lsu_cmd_addr = LA; lsu_cmd_wdata = LW; lsu_cmd_wmask = LM;
        ext_cmd_read = 1'b0; ext_cmd_addr = EA; ext_cmd_wdata = EW; ext_cmd_wmask = EM;
        lsu_cmd_valid = 0; ext_cmd_valid = 0; dtcm_cmd_ready = 0; dtcm_rsp_valid = 0;
        lsu_rsp_ready = 0; ext_rsp_ready = 0; dtcm_rsp_rdata = '0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1 quiet_checks("reset");
        @(negedge clk) rst_n = 1'b1;
        // Lone LSU read, response one cycle later.
        step(vec_t'{1, 0, 1, 0, 0, 0, 32'h0,         1, 1, 0, 0, 0});
        step(vec_t'{0, 0, 1, 1, 1, 0, 32'hDEAD_BEEF, 0, 1, 0, 0, 1});
        // Fresh reset so the round-robin starts with LSU winning the first tie.
        @(negedge clk) rst_n = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        for (int i = 0; i < 15; i++) step(tbl[i]);
        // Stalled EXT grant stays locked while LSU competes; LSU wins right after.
        step(vec_t'{0, 1, 0, 0, 0, 0, 32'h0,         1, 0, 0, 1, 0});
        step(vec_t'{1, 1, 0, 0, 0, 0, 32'h0,         1, 0, 0, 1, 0});
        step(vec_t'{1, 1, 0, 0, 0, 0, 32'h0,         1, 0, 0, 1, 0});
        step(vec_t'{1, 1, 1, 1, 1, 1, 32'hC000_0001, 1, 0, 1, 1, 1});
        step(vec_t'{1, 0, 1, 0, 0, 0, 32'h0,         1, 1, 0, 0, 0});
        step(vec_t'{0, 0, 0, 1, 1, 1, 32'hC000_0002, 0, 0, 0, 0, 1});
        step(vec_t'{0, 0, 0, 1, 1, 1, 32'hC000_0003, 0, 0, 0, 0, 1});
        chk("scoreboard_drained", q.size(), 0);
        // Reset with two commands outstanding; a stale response afterwards must be dropped.
        step(vec_t'{1, 0, 1, 0, 0, 0, 32'h0,         1, 1, 0, 0, 0});
        step(vec_t'{1, 0, 1, 0, 0, 0, 32'h0,         1, 1, 0, 0, 0});
        @(negedge clk);
        lsu_cmd_valid = 0; ext_cmd_valid = 0; dtcm_cmd_ready = 0;
        dtcm_rsp_valid = 0; lsu_rsp_ready = 0; ext_rsp_ready = 0; dtcm_rsp_rdata = '0;
        #2 rst_n = 1'b0;
        #1 quiet_checks("midreset");
        q.delete();
        @(negedge clk) rst_n = 1'b1;
        step(vec_t'{0, 0, 0, 1, 1, 1, 32'h57A1_E000, 0, 0, 0, 0, 0});
        step(vec_t'{1, 0, 1, 0, 0, 0, 32'h0,         1, 1, 0, 0, 0});
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
